// File: rtl/draw_player_pkg.sv
// draw_player_pkg: shared widths, default key colour, timing bundle and span helper.
package draw_player_pkg;
  localparam int TW = 11;
  localparam int RGBW = 12;
  localparam int AW = 12;
  localparam logic [RGBW-1:0] DEFAULT_KEY = 12'hF0F;
  typedef struct packed {
    logic [TW-1:0] vcount;
    logic [TW-1:0] hcount;
    logic          vsync;
    logic          vblnk;
    logic          hsync;
    logic          hblnk;
  } timing_t;
  // The end point is formed one bit wider than the counter so a box near 2047 never wraps to 0.
  function automatic logic in_span(input logic [TW-1:0] pos, input logic [TW-1:0] cnt, input logic [TW:0] size);
    return (cnt >= pos) && ({1'b0, cnt} < ({1'b0, pos} + size));
  endfunction
endpackage

// File: rtl/draw_player_timing_delay.sv
// timing_delay: delays the timing bundle by DEPTH pclk cycles.
// Ports: i_clk clock, i_rst_n async active-low reset, i_t timing in,
//        o_t timing after DEPTH cycles, o_blnk1 (h|v)blank of the first stage.
module timing_delay
  import draw_player_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  timing_t i_t,
  output timing_t o_t,
  output logic    o_blnk1
);
  timing_t r_pipe [DEPTH];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_t;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  assign o_t = r_pipe[DEPTH-1];
  assign o_blnk1 = r_pipe[0].hblnk | r_pipe[0].vblnk;
endmodule

// File: rtl/draw_player.sv
// draw_player: two-stage sprite compositor over a background video stream.
// Ports: pclk_in clock, rst_in async active-low reset; *_in timing/rgb from the background
//        stage; xpos_in/ypos_in/flip_in requested sprite placement (latched at vblank rise);
//        pixel_addr/rgb_pixel sprite ROM interface; *_out timing delayed 2 cycles; rgb_out pixel.
module draw_player
  import draw_player_pkg::*;
#(
  parameter int              SPRITE_W  = 32,
  parameter int              SPRITE_H  = 48,
  parameter logic [RGBW-1:0] KEY_COLOR = DEFAULT_KEY
) (
  input  logic            pclk_in,
  input  logic            rst_in,
  input  logic [TW-1:0]   vcount_in,
  input  logic [TW-1:0]   hcount_in,
  input  logic            vsync_in,
  input  logic            vblnk_in,
  input  logic            hsync_in,
  input  logic            hblnk_in,
  input  logic [RGBW-1:0] rgb_in,
  input  logic [TW-1:0]   xpos_in,
  input  logic [TW-1:0]   ypos_in,
  input  logic            flip_in,
  output logic [AW-1:0]   pixel_addr,
  input  logic [RGBW-1:0] rgb_pixel,
  output logic [TW-1:0]   vcount_out,
  output logic [TW-1:0]   hcount_out,
  output logic            vsync_out,
  output logic            vblnk_out,
  output logic            hsync_out,
  output logic            hblnk_out,
  output logic [RGBW-1:0] rgb_out
);
  timing_t         w_t_in;
  timing_t         w_t_out;
  logic            w_blnk1;
  logic            w_vb_rise;
  logic            w_inside;
  logic [5:0]      w_dx;
  logic [5:0]      w_dy;
  logic [5:0]      w_col;
  logic            r_vblnk_prev;
  logic [TW-1:0]   r_xpos;
  logic [TW-1:0]   r_ypos;
  logic            r_flip;
  logic            r_inside;
  logic [RGBW-1:0] r_rgb;
  logic [AW-1:0]   r_pixel_addr;
  logic [RGBW-1:0] r_rgb_out;
  assign w_t_in = {vcount_in, hcount_in, vsync_in, vblnk_in, hsync_in, hblnk_in};
  timing_delay #(.DEPTH(2)) u_timing_delay (
    .i_clk   (pclk_in),
    .i_rst_n (rst_in),
    .i_t     (w_t_in),
    .o_t     (w_t_out),
    .o_blnk1 (w_blnk1)
  );
  assign {vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out} = w_t_out;
  assign w_vb_rise = vblnk_in & ~r_vblnk_prev;
  // Offsets only need 6 bits: the low bits of a difference depend only on the operands' low bits.
  always_comb begin
    w_inside = in_span(r_xpos, hcount_in, (TW+1)'(SPRITE_W)) & in_span(r_ypos, vcount_in, (TW+1)'(SPRITE_H));
    w_dx = hcount_in[5:0] - r_xpos[5:0];
    w_dy = vcount_in[5:0] - r_ypos[5:0];
    w_col = r_flip ? 6'(SPRITE_W - 1) - w_dx : w_dx;
  end
  // Placement updates at the vblank edge; this cycle's pixel still uses the old placement.
  always_ff @(posedge pclk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_vblnk_prev <= 1'b0;
      r_xpos <= '0;
      r_ypos <= '0;
      r_flip <= 1'b0;
    end else begin
      r_vblnk_prev <= vblnk_in;
      if (w_vb_rise) begin
        r_xpos <= xpos_in;
        r_ypos <= ypos_in;
        r_flip <= flip_in;
      end
    end
  end
  always_ff @(posedge pclk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_inside <= 1'b0;
      r_rgb <= '0;
      r_pixel_addr <= '0;
      r_rgb_out <= '0;
    end else begin
      r_inside <= w_inside;
      r_rgb <= rgb_in;
      r_pixel_addr <= w_inside ? {w_dy, w_col} : '0;
      r_rgb_out <= w_blnk1 ? '0 : (r_inside && rgb_pixel != KEY_COLOR) ? rgb_pixel : r_rgb;
    end
  end
  assign pixel_addr = r_pixel_addr;
  assign rgb_out = r_rgb_out;
endmodule

// File: tb/tb_draw_player.sv
// tb_draw_player: directed and randomized checks of draw_player against a behavioural model.
module tb_draw_player;
  localparam int SW = 32;
  localparam int SH = 48;
  localparam logic [11:0] KEY = 12'hF0F;
  logic pclk_in = 1'b0;
  logic rst_in = 1'b0;
  logic [10:0] vcount_in, hcount_in, xpos_in, ypos_in;
  logic vsync_in, vblnk_in, hsync_in, hblnk_in, flip_in;
  logic [11:0] rgb_in, rgb_pixel, pixel_addr, rgb_out;
  logic [10:0] vcount_out, hcount_out;
  logic vsync_out, vblnk_out, hsync_out, hblnk_out;
  logic [25:0] t_out;
  int errs = 0;
  int checks = 0;
  always #5 pclk_in = ~pclk_in;
  draw_player #(.SPRITE_W(SW), .SPRITE_H(SH), .KEY_COLOR(KEY)) dut (
    .pclk_in(pclk_in), .rst_in(rst_in),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .vblnk_in(vblnk_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .xpos_in(xpos_in), .ypos_in(ypos_in), .flip_in(flip_in),
    .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .vblnk_out(vblnk_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out)
  );
  assign t_out = {vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out};
  // Sprite ROM stand-in: every address ending in nibble 5 is transparent.
  function automatic logic [11:0] rom(input logic [11:0] a);
    logic [11:0] v;
    v = {a[11:6] ^ 6'h2A, a[5:0]};
    return (a[3:0] == 4'h5) ? KEY : (v == KEY ? 12'h0F0 : v);
  endfunction
  assign rgb_pixel = rom(pixel_addr);
  typedef struct {
    logic [25:0] t;
    logic [11:0] rgb;
    bit          in;
    logic [11:0] addr;
  } rec_t;
  rec_t h1, h2;
  int mx, my;
  bit mf, mpv;
  logic [11:0] e_addr, e_rgb;
  logic [25:0] e_t;
  // Model: placement per frame, box test in plain integers, two-slot history of pixels.
  task automatic model_tick();
    rec_t r;
    int dx, dy;
    if (!rst_in) begin
      mx = 0; my = 0; mf = 0; mpv = 0;
      h1 = '{t: '0, rgb: '0, in: 0, addr: '0};
      h2 = h1;
    end else begin
      dx = int'(hcount_in) - mx;
      dy = int'(vcount_in) - my;
      r.t = {vcount_in, hcount_in, vsync_in, vblnk_in, hsync_in, hblnk_in};
      r.rgb = rgb_in;
      r.in = dx >= 0 && dx < SW && dy >= 0 && dy < SH;
      r.addr = r.in ? 12'(dy * 64 + (mf ? SW - 1 - dx : dx)) : 12'h000;
      h2 = h1;
      h1 = r;
      if (vblnk_in && !mpv) begin
        mx = int'(xpos_in); my = int'(ypos_in); mf = flip_in;
      end
      mpv = vblnk_in;
    end
    e_addr = h1.addr;
    e_t = h2.t;
    e_rgb = (h2.t[2] | h2.t[0]) ? 12'h000 : (h2.in && rom(h2.addr) != KEY) ? rom(h2.addr) : h2.rgb;
  endtask
  task automatic drive(input logic [10:0] hc, input logic [10:0] vc, input logic hb, input logic vb,
                       input logic [11:0] rgb, input logic [10:0] xp, input logic [10:0] yp, input logic fl);
    hcount_in = hc; vcount_in = vc; hblnk_in = hb; vblnk_in = vb;
    hsync_in = hc[3]; vsync_in = vc[2];
    rgb_in = rgb; xpos_in = xp; ypos_in = yp; flip_in = fl;
  endtask
  task automatic cyc();
    @(posedge pclk_in);
    model_tick();
    @(negedge pclk_in);
  endtask
  task automatic set_pos(input logic [10:0] x, input logic [10:0] y, input logic f);
    drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h000, x, y, f); cyc();
    drive(11'd0, 11'd0, 1'b0, 1'b1, 12'h000, x, y, f); cyc();
    drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h000, x, y, f); cyc();
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(11'($urandom), 11'($urandom), 1'b0, 1'b1, 12'($urandom), 11'd77, 11'd88, 1'b1);
      cyc();
      checks++;
      if ({t_out, pixel_addr, rgb_out} !== 50'd0) begin
        errs++; $display("FAIL reset_outputs cyc %0d: got %h expected 0", i, {t_out, pixel_addr, rgb_out});
      end
    end
    rst_in = 1'b1;
  endtask
  task automatic test_pos_latency();
    set_pos(11'd100, 11'd200, 1'b0);
    drive(11'd100, 11'd200, 1'b0, 1'b0, 12'h456, 11'd100, 11'd200, 1'b0); cyc();
    checks++;
    if (pixel_addr !== 12'h000) begin
      errs++; $display("FAIL latency_addr: got %h expected 000", pixel_addr);
    end
    drive(11'd101, 11'd200, 1'b0, 1'b0, 12'h456, 11'd100, 11'd200, 1'b0); cyc();
    checks++;
    if (rgb_out !== rom(12'h000) || hcount_out !== 11'd100 || vcount_out !== 11'd200) begin
      errs++; $display("FAIL latency_rgb: got %h@%0d,%0d expected %h@100,200", rgb_out, hcount_out, vcount_out, rom(12'h000));
    end
  endtask
  task automatic test_flip();
    set_pos(11'd100, 11'd200, 1'b1);
    drive(11'd105, 11'd210, 1'b0, 1'b0, 12'h321, 11'd100, 11'd200, 1'b1); cyc();
    checks++;
    if (pixel_addr !== {6'd10, 6'd26}) begin
      errs++; $display("FAIL flip_addr: got %h expected %h", pixel_addr, {6'd10, 6'd26});
    end
  endtask
  task automatic test_key();
    set_pos(11'd100, 11'd200, 1'b0);
    drive(11'd105, 11'd210, 1'b0, 1'b0, 12'h123, 11'd100, 11'd200, 1'b0); cyc();
    drive(11'd106, 11'd210, 1'b0, 1'b0, 12'h999, 11'd100, 11'd200, 1'b0); cyc();
    checks++;
    if (rgb_out !== 12'h123) begin
      errs++; $display("FAIL key_transparent: got %h expected 123", rgb_out);
    end
  endtask
  task automatic test_no_tear();
    logic [10:0] hcs [5];
    logic        vbs [5];
    logic [11:0] exp [5];
    hcs = '{11'd300, 11'd400, 11'd300, 11'd400, 11'd300};
    vbs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp = '{12'h040, 12'h000, 12'h040, 12'h040, 12'h000};
    set_pos(11'd300, 11'd200, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(hcs[i], 11'd201, 1'b0, vbs[i], 12'h777, 11'd400, 11'd200, 1'b0); cyc();
      checks++;
      if (pixel_addr !== exp[i]) begin
        errs++; $display("FAIL no_tear step %0d: got %h expected %h", i, pixel_addr, exp[i]);
      end
    end
  endtask
  task automatic test_right_edge();
    set_pos(11'd1270, 11'd0, 1'b0);
    drive(11'd1279, 11'd5, 1'b0, 1'b0, 12'hABC, 11'd1270, 11'd0, 1'b0); cyc();
    checks++;
    if (pixel_addr !== {6'd5, 6'd9}) begin
      errs++; $display("FAIL edge_1279: got %h expected %h", pixel_addr, {6'd5, 6'd9});
    end
    for (int h = 0; h < 10; h++) begin
      drive(11'(h), 11'd5, 1'b0, 1'b0, 12'hABC, 11'd1270, 11'd0, 1'b0); cyc();
      checks++;
      if (pixel_addr !== 12'h000) begin
        errs++; $display("FAIL edge_nowrap h=%0d: got %h expected 000", h, pixel_addr);
      end
    end
    drive(11'd1275, 11'd5, 1'b1, 1'b0, 12'hABC, 11'd1270, 11'd0, 1'b0); cyc();
    drive(11'd1276, 11'd5, 1'b0, 1'b0, 12'hABC, 11'd1270, 11'd0, 1'b0); cyc();
    checks++;
    if (rgb_out !== 12'h000) begin
      errs++; $display("FAIL blank_black: got %h expected 000", rgb_out);
    end
  endtask
  task automatic test_reset_mid();
    set_pos(11'd50, 11'd60, 1'b0);
    drive(11'd55, 11'd61, 1'b0, 1'b0, 12'h5A5, 11'd50, 11'd60, 1'b0); cyc();
    drive(11'd56, 11'd61, 1'b0, 1'b0, 12'h5A5, 11'd50, 11'd60, 1'b0);
    #2 rst_in = 1'b0;
    #1;
    checks++;
    if ({t_out, pixel_addr, rgb_out} !== 50'd0) begin
      errs++; $display("FAIL reset_async: got %h expected 0", {t_out, pixel_addr, rgb_out});
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({t_out, pixel_addr, rgb_out} !== 50'd0) begin
        errs++; $display("FAIL reset_mid cyc %0d: got %h expected 0", i, {t_out, pixel_addr, rgb_out});
      end
    end
    rst_in = 1'b1;
    drive(11'd0, 11'd1, 1'b0, 1'b0, 12'h222, 11'd50, 11'd60, 1'b0); cyc();
    checks++;
    if (pixel_addr !== 12'h040) begin
      errs++; $display("FAIL reset_origin_addr: got %h expected 040", pixel_addr);
    end
    drive(11'd1, 11'd1, 1'b0, 1'b0, 12'h222, 11'd50, 11'd60, 1'b0); cyc();
    checks++;
    if (rgb_out !== rom(12'h040) || hcount_out !== 11'd0 || vcount_out !== 11'd1) begin
      errs++; $display("FAIL reset_latency: got %h@%0d,%0d expected %h@0,1", rgb_out, hcount_out, vcount_out, rom(12'h040));
    end
  endtask
  task automatic test_random();
    logic [10:0] hc, vc;
    for (int i = 0; i < 600; i++) begin
      hc = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'(mx + int'($urandom_range(0, 40)) - 4);
      vc = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'(my + int'($urandom_range(0, 56)) - 4);
      drive(hc, vc, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, 12'($urandom),
            ($urandom_range(0, 1) == 0) ? 11'($urandom) : 11'($urandom_range(2000, 2047)),
            ($urandom_range(0, 1) == 0) ? 11'($urandom) : 11'($urandom_range(2000, 2047)),
            1'($urandom));
      cyc();
      checks++;
      if (pixel_addr !== e_addr) begin
        errs++; $display("FAIL rand_addr i=%0d: got %h expected %h", i, pixel_addr, e_addr);
      end
      checks++;
      if (rgb_out !== e_rgb) begin
        errs++; $display("FAIL rand_rgb i=%0d: got %h expected %h", i, rgb_out, e_rgb);
      end
      checks++;
      if (t_out !== e_t) begin
        errs++; $display("FAIL rand_timing i=%0d: got %h expected %h", i, t_out, e_t);
      end
    end
  endtask
  initial begin
    drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h000, 11'd0, 11'd0, 1'b0);
    test_reset();
    test_pos_latency();
    test_flip();
    test_key();
    test_no_tear();
    test_right_edge();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/draw_player.md
DRAW_PLAYER -- requirements
Module: draw_player

Interface
REQ-001 SHALL have parameter SPRITE_W, default 32, sprite width in pixels, 1..64.
REQ-002 SHALL have parameter SPRITE_H, default 48, sprite height in pixels, 1..64.
REQ-003 SHALL have parameter KEY_COLOR, default 12'hF0F, transparent ROM colour.
REQ-004 SHALL have port pclk_in  input  1  pixel clock; the single clock, all logic on its rising edge.
REQ-005 SHALL have port rst_in  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports vcount_in, hcount_in  input  11 each  timing counters from the background stage.
REQ-007 SHALL have ports vsync_in, vblnk_in, hsync_in, hblnk_in  input  1 each  timing strobes from the background stage.
REQ-008 SHALL have port rgb_in  input  12  background pixel {r,g,b}.
REQ-009 SHALL have ports xpos_in, ypos_in  input  11 each  requested sprite top-left corner.
REQ-010 SHALL have port flip_in  input  1  requested horizontal mirror.
REQ-011 SHALL have port pixel_addr  output  12  sprite ROM address {row[5:0], col[5:0]}.
REQ-012 SHALL have port rgb_pixel  input  12  sprite ROM data, combinational from pixel_addr.
REQ-013 SHALL have ports vcount_out, hcount_out  output  11 each, and vsync_out, vblnk_out, hsync_out, hblnk_out  output  1 each  delayed timing.
REQ-014 SHALL have port rgb_out  output  12  composited pixel.

Function
REQ-015 Every *_out timing signal SHALL equal its *_in counterpart delayed exactly 2 pclk_in cycles.
REQ-016 Stage 1 SHALL register the timing inputs and rgb_in, an inside flag, and pixel_addr.
REQ-017 Stage 2 SHALL register the stage-1 timing and the composited rgb_out computed from stage-1 rgb, the inside flag and rgb_pixel.
REQ-018 Working registers xpos_q, ypos_q and flip_q SHALL load xpos_in, ypos_in and flip_in only on the cycle vblnk_in is 1 and its previous sampled value was 0 (vblank rising edge).
REQ-019 At all other times the working registers SHALL hold, so position changes never tear mid-frame.
REQ-020 inside SHALL be 1 iff xpos_q <= hcount_in < xpos_q+SPRITE_W and ypos_q <= vcount_in < ypos_q+SPRITE_H.
REQ-021 The sums in REQ-020 SHALL be computed 12 bits wide, so a sprite at x=2040 does not wrap to column 0.
REQ-022 dx SHALL be hcount_in-xpos_q and dy SHALL be vcount_in-ypos_q.
REQ-023 The column field SHALL be dx when flip_q=0 and SPRITE_W-1-dx when flip_q=1.
REQ-024 When inside=0, pixel_addr SHALL hold 12'h000.
REQ-025 rgb_out SHALL be 12'h000 when stage-1 hblnk or vblnk is 1.
REQ-026 Otherwise rgb_out SHALL be rgb_pixel when inside=1 and rgb_pixel != KEY_COLOR.
REQ-027 Otherwise rgb_out SHALL be the stage-1 rgb.
REQ-028 Simultaneous vblank rising edge and inside=1 SHALL use the old position for that pixel; the new position applies from the next cycle.

Reset
REQ-029 While rst_in=0, all pipeline registers, pixel_addr, rgb_out, the vblnk edge register, xpos_q, ypos_q and flip_q SHALL be 0.
REQ-030 Reset assertion mid-frame SHALL clear immediately; after release the outputs SHALL be valid 2 cycles later, with the sprite at (0,0) until the next vblank edge.

Structure
REQ-031 The shared package SHALL hold the timing width (11), the RGB width (12), the ROM address width (12) and the default KEY_COLOR.
REQ-032 The timing delay SHALL be one sub-module, timing_delay, parameterised by depth (2), instantiated once.

Verification
REQ-033 pos (100,200), flip=0, applied before vblank: pixel (hcount 100, vcount 200) -> pixel_addr 12'h000 one cycle later, ROM value on rgb_out 2 cycles later.
REQ-034 flip=1, SPRITE_W=32, pixel (105,210) -> pixel_addr {6'd10, 6'd26}.
REQ-035 ROM returns 12'hF0F inside the box with rgb_in=12'h123 -> rgb_out=12'h123.
REQ-036 xpos_in changed 300->400 mid-frame (vblnk=0) -> the sprite stays at column 300 until the vblnk rising edge, then column 400.
REQ-037 xpos_q=1270 -> inside at hcount 1279, no sprite pixel at hcount 0..9; the blanking region is black.
REQ-038 rst_in pulsed low for 3 cycles mid-line -> all outputs 0 during reset, latency 2 restored, position (0,0).
